bus_dev_endpoint: RTL and testbench

Device-side endpoint of the bus generator/arbiter FIFO protocol: one instance per device port. It holds outgoing packets in a show-ahead TX FIFO that the bus drains through `pndng`/`pop`/`D_pop`. It captures packets the bus delivers through `push`/`D_push` into an RX FIFO for the host. It replaces the behavioural FIFO models on the DUT side, so the arbiter can be integrated with synthesizable device ports.

---
 rtl/bus_dev_pkg.sv | 20 ++
 rtl/bus_dev_fifo.sv | 53 +++++
 rtl/bus_dev_endpoint.sv | 84 ++++++++
 tb/tb_bus_dev_endpoint.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bus_dev_pkg.sv
// bus_dev_pkg: default widths, broadcast ID and packet helpers shared by the device endpoint.
package bus_dev_pkg;

    localparam int PKT_W        = 32;
    localparam int ID_W         = 8;
    localparam int FIFO_DEPTH   = 8;
    localparam int BROADCAST_ID = 145;

    typedef struct packed {
        logic [ID_W-1:0]       dest;
        logic [PKT_W-ID_W-1:0] payload;
    } pkt_t;

    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_W-1:0] pkt);
        pkt_t p;
        p = pkt;
        return p.dest;
    endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: synchronous show-ahead FIFO; a push while full is accepted when a pop frees the head in the same cycle.
module bus_dev_fifo
    import bus_dev_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    // Stale storage is masked so the head reads 0 whenever nothing is queued.
    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: device port of the bus arbiter with a show-ahead TX FIFO and a filtered RX FIFO.
// Define BUS_DEV_ADDR_FILTER_EN to accept only packets addressed to id or broadcast.
module bus_dev_endpoint
    import bus_dev_pkg::*;
#(
    parameter int tama_de_paquete = PKT_W,
    parameter int BITS            = ID_W,
    parameter int tam_fifo        = FIFO_DEPTH,
    parameter int broadcast       = BROADCAST_ID,
    parameter int id              = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       pndng,
    input  logic                       pop,
    output logic [tama_de_paquete-1:0] D_pop,
    input  logic                       push,
    input  logic [tama_de_paquete-1:0] D_push,
    input  logic                       wr_en,
    input  logic [tama_de_paquete-1:0] wr_data,
    output logic                       tx_full,
    input  logic                       rd_en,
    output logic [tama_de_paquete-1:0] rd_data,
    output logic                       rx_empty,
    output logic [$clog2(tam_fifo):0]  rx_count,
    output logic [15:0]                drop_cnt
);

    logic                      w_tx_empty;
    logic [$clog2(tam_fifo):0] w_tx_count_unused;
    logic                      w_rx_full;
    logic                      w_pass;
    logic                      w_accept;
    logic                      w_drop;
    logic [15:0]               r_drop_cnt;

    bus_dev_fifo #(.WIDTH(tama_de_paquete), .DEPTH(tam_fifo)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (D_pop),
        .full  (tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count_unused)
    );

    assign pndng = !w_tx_empty;

`ifdef BUS_DEV_ADDR_FILTER_EN
    logic [BITS-1:0] w_dest;
    assign w_dest = D_push[tama_de_paquete-1 -: BITS];
    assign w_pass = (w_dest == BITS'(id)) || (w_dest == BITS'(broadcast));
`else
    // The arbiter routes correctly, so the addresses are not consulted.
    logic [BITS-1:0] w_ids_unused;
    assign w_ids_unused = BITS'(id) ^ BITS'(broadcast);
    assign w_pass       = 1'b1;
`endif

    assign w_accept = push && w_pass;
    assign w_drop   = w_accept && w_rx_full && !rd_en;

    bus_dev_fifo #(.WIDTH(tama_de_paquete), .DEPTH(tam_fifo)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_accept),
        .pop   (rd_en),
        .din   (D_push),
        .dout  (rd_data),
        .full  (w_rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb_bus_dev_endpoint: directed and randomized checks of bus_dev_endpoint against a queue-based model.
module tb_bus_dev_endpoint;

    localparam int W  = 32;
    localparam int B  = 8;
    localparam int D  = 8;
    localparam int ID = 3;
    localparam int BC = 145;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         pndng, tx_full, rx_empty;
    logic         pop = 1'b0, push = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [W-1:0] D_pop, rd_data;
    logic [W-1:0] D_push = '0, wr_data = '0;
    logic [3:0]   rx_count;
    logic [15:0]  drop_cnt;

    int total = 0;
    int bad = 0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];
    int drops = 0;

    always #5 clk = ~clk;

    bus_dev_endpoint #(
        .tama_de_paquete(W), .BITS(B), .tam_fifo(D), .broadcast(BC), .id(ID)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .pop(pop), .D_pop(D_pop),
        .push(push), .D_push(D_push), .wr_en(wr_en), .wr_data(wr_data),
        .tx_full(tx_full), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
        .rx_count(rx_count), .drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit accepts(input logic [W-1:0] p);
`ifdef BUS_DEV_ADDR_FILTER_EN
        return (p[W-1 -: B] == B'(ID)) || (p[W-1 -: B] == B'(BC));
`else
        return p[0] | !p[0];
`endif
    endfunction

    // Reference: plain queues updated from the pre-edge inputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q.delete();
            rx_q.delete();
            drops = 0;
        end else begin
            bit tp, rr;
            tp = pop && tx_q.size() > 0;
            if (tp) tx_q.delete(0);
            if (wr_en && tx_q.size() < D) tx_q.push_back(wr_data);
            rr = rd_en && rx_q.size() > 0;
            if (rr) rx_q.delete(0);
            if (push && accepts(D_push)) begin
                if (rx_q.size() < D) rx_q.push_back(D_push);
                else if (drops < 65535) drops++;
            end
        end
    end

    always @(negedge clk) begin
        check("pndng", 32'(pndng), 32'(tx_q.size() != 0));
        check("tx_full", 32'(tx_full), 32'(tx_q.size() == D));
        check("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
        check("rx_count", 32'(rx_count), 32'(rx_q.size()));
        check("drop_cnt", 32'(drop_cnt), 32'(drops));
        if (tx_q.size() != 0) check("D_pop", D_pop, tx_q[0]);
        if (rx_q.size() != 0) check("rd_data", rd_data, rx_q[0]);
    end

    task automatic step(input logic w, input logic [W-1:0] wd, input logic p,
                        input logic ps, input logic [W-1:0] dp, input logic r);
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [W-1:0] dp;
        int pw, pp;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pndng", 32'(pndng), 0);
        check("rst_tx_full", 32'(tx_full), 0);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_rx_count", 32'(rx_count), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_D_pop", D_pop, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 8; i++) step(1, 32'h0300_0000 + i, 0, 0, 0, 0);
        check("fill_full", 32'(tx_full), 1);
        step(1, 32'h0300_0009, 0, 0, 0, 0);
        check("ninth_full", 32'(tx_full), 1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", D_pop, 32'h0300_0000 + i);
            step(0, 0, 1, 0, 0, 0);
        end
        check("drain_pndng", 32'(pndng), 0);

        for (int i = 1; i <= 8; i++) step(1, 32'h0400_0000 + i, 0, 0, 0, 0);
        step(1, 32'hDEAD_BEEF, 1, 0, 0, 0);
        check("full_wp_full", 32'(tx_full), 1);
        check("full_wp_head", D_pop, 32'h0400_0002);
        repeat (7) step(0, 0, 1, 0, 0, 0);
        check("full_wp_new", D_pop, 32'hDEAD_BEEF);
        step(0, 0, 1, 0, 0, 0);
        check("full_wp_empty", 32'(pndng), 0);

        step(0, 0, 0, 1, 32'h0300_00AA, 0);
        step(0, 0, 0, 1, {8'(BC), 24'h0000BB}, 0);
        step(0, 0, 0, 1, 32'h0700_00CC, 0);
`ifdef BUS_DEV_ADDR_FILTER_EN
        check("filter_count", 32'(rx_count), 2);
`else
        check("filter_count", 32'(rx_count), 3);
`endif
        check("filter_rd0", rd_data, 32'h0300_00AA);
        step(0, 0, 0, 0, 0, 1);
        check("filter_rd1", rd_data, 32'h9100_00BB);
        step(0, 0, 0, 0, 0, 1);
`ifndef BUS_DEV_ADDR_FILTER_EN
        check("filter_rd2", rd_data, 32'h0700_00CC);
        step(0, 0, 0, 0, 0, 1);
`endif
        check("filter_empty", 32'(rx_empty), 1);

        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 32'h0300_0100 + i, 0);
        check("ovf_count", 32'(rx_count), 8);
        check("ovf_drops", 32'(drop_cnt), 2);
        for (int i = 0; i < 8; i++) begin
            check("ovf_data", rd_data, 32'h0300_0100 + i);
            step(0, 0, 0, 0, 0, 1);
        end
        check("ovf_empty", 32'(rx_empty), 1);

        for (int i = 0; i < 5; i++) step(1, 32'h0300_0200 + i, 0, 1, 32'h0300_0300 + i, 0);
        reset = 1'b0;
        #1;
        check("midrst_pndng", 32'(pndng), 0);
        check("midrst_D_pop", D_pop, 0);
        check("midrst_rx_empty", 32'(rx_empty), 1);
        check("midrst_drop_cnt", 32'(drop_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            step(1, 32'h0500_0000 + i, 0, 1, 32'h0300_0400 + i, 0);
            check("wrap_tx", D_pop, 32'h0500_0000 + i);
            check("wrap_rx", rd_data, 32'h0300_0400 + i);
            step(0, 0, 1, 0, 0, 1);
        end
        check("wrap_pndng", 32'(pndng), 0);
        check("wrap_rx_empty", 32'(rx_empty), 1);

        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 25;
            pp = 100 - pw;
            repeat (600) begin
                case ($urandom_range(3))
                    0: dp = {8'(ID), 24'($urandom)};
                    1: dp = {8'(BC), 24'($urandom)};
                    2: dp = {8'd7, 24'($urandom)};
                    default: dp = $urandom;
                endcase
                step($urandom_range(99) < pw, $urandom, $urandom_range(99) < pp,
                     $urandom_range(99) < pw, dp, $urandom_range(99) < pp);
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
